// File: rtl/uart_rx_deserializer_if.sv
// Host-facing signal bundle for the UART receive stage: serial line, oversample tick,
// and the byte valid/ack handshake with its error flags.
interface uart_rx_deserializer_if #(
    parameter int unsigned DATA_W = 8
);
    logic              rx;
    logic              tick_rx;
    logic              rx_ack;
    logic [DATA_W-1:0] data_out;
    logic              rx_valid;
    logic              parity_err;
    logic              frame_err;
    logic              overrun;
    logic              rx_busy;

    modport master (
        output rx, tick_rx, rx_ack,
        input  data_out, rx_valid, parity_err, frame_err, overrun, rx_busy
    );

    modport slave (
        input  rx, tick_rx, rx_ack,
        output data_out, rx_valid, parity_err, frame_err, overrun, rx_busy
    );
endinterface

// File: rtl/uart_rx_deserializer.sv
// UART receiver: 8E2 frames oversampled by tick_rx, byte + flags held on a valid/ack handshake.
// Optional UART_RX_MAJORITY_EN: each bit is the majority of the last three tick samples.
module uart_rx_deserializer #(
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned DATA_W     = 8
) (
    input logic                   clk,
    input logic                   rst,
    uart_rx_deserializer_if.slave bus
);
    localparam int unsigned      TickW    = $clog2(OVERSAMPLE);
    localparam int unsigned      BitW     = $clog2(DATA_W);
    localparam logic [TickW-1:0] StartMid = TickW'(OVERSAMPLE / 2 - 1);
    localparam logic [TickW-1:0] BitMid   = TickW'(OVERSAMPLE - 1);
    localparam logic [BitW-1:0]  LastBit  = BitW'(DATA_W - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop1,
        StStop2
    } state_e;

    state_e            state_q, state_d;
    logic [TickW-1:0]  tick_cnt_q, tick_cnt_d;
    logic [BitW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic              p_err_q, p_err_d;
    logic              f_err_q, f_err_d;
    logic              armed_q, armed_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              perr_q, perr_d;
    logic              ferr_q, ferr_d;
    logic              ovr_q, ovr_d;
    logic [1:0]        sync_q;
    logic              rx_s;
    logic              sample;
    logic              commit;

    always_ff @(posedge clk) begin
        if (rst) sync_q <= 2'b11;
        else     sync_q <= {sync_q[0], bus.rx};
    end
    assign rx_s = sync_q[1];

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] hist_q;

    always_ff @(posedge clk) begin
        if (rst)              hist_q <= 2'b11;
        else if (bus.tick_rx) hist_q <= {hist_q[0], rx_s};
    end
    assign sample = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx_s) | (hist_q[0] & rx_s);
`else
    assign sample = rx_s;
`endif

    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shreg_d    = shreg_q;
        p_err_d    = p_err_q;
        f_err_d    = f_err_q;
        armed_d    = armed_q;
        commit     = 1'b0;
        if (bus.tick_rx) begin
            tick_cnt_d = tick_cnt_q + TickW'(1);
            unique case (state_q)
                StIdle: begin
                    tick_cnt_d = '0;
                    // A held-low line (break) must go high before another start is accepted.
                    if (rx_s)         armed_d = 1'b1;
                    else if (armed_q) state_d = StStart;
                end
                StStart: begin
                    if (tick_cnt_q == StartMid) begin
                        tick_cnt_d = '0;
                        if (sample) begin
                            state_d = StIdle;
                            armed_d = 1'b1;
                        end else begin
                            state_d = StData;
                        end
                    end
                end
                StData: begin
                    if (tick_cnt_q == BitMid) begin
                        tick_cnt_d = '0;
                        shreg_d    = {sample, shreg_q[DATA_W-1:1]};
                        bit_cnt_d  = bit_cnt_q + BitW'(1);
                        if (bit_cnt_q == LastBit) begin
                            bit_cnt_d = '0;
                            state_d   = StParity;
                        end
                    end
                end
                StParity: begin
                    if (tick_cnt_q == BitMid) begin
                        tick_cnt_d = '0;
                        p_err_d    = sample ^ (^shreg_q);
                        state_d    = StStop1;
                    end
                end
                StStop1: begin
                    if (tick_cnt_q == BitMid) begin
                        tick_cnt_d = '0;
                        f_err_d    = ~sample;
                        state_d    = StStop2;
                    end
                end
                StStop2: begin
                    if (tick_cnt_q == BitMid) begin
                        tick_cnt_d = '0;
                        f_err_d    = f_err_q | ~sample;
                        armed_d    = sample;
                        commit     = 1'b1;
                        state_d    = StIdle;
                    end
                end
                default: begin
                    tick_cnt_d = '0;
                    state_d    = StIdle;
                end
            endcase
        end
    end

    // The receiver never stalls: a byte arriving while the previous one is unread is dropped.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        perr_d  = perr_q;
        ferr_d  = ferr_q;
        ovr_d   = ovr_q;
        if (commit) begin
            if (!valid_q || bus.rx_ack) begin
                data_d  = shreg_q;
                perr_d  = p_err_q;
                ferr_d  = f_err_d;
                valid_d = 1'b1;
                if (bus.rx_ack) ovr_d = 1'b0;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (bus.rx_ack && valid_q) begin
            valid_d = 1'b0;
            perr_d  = 1'b0;
            ferr_d  = 1'b0;
            ovr_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shreg_q    <= '0;
            p_err_q    <= 1'b0;
            f_err_q    <= 1'b0;
            armed_q    <= 1'b0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shreg_q    <= shreg_d;
            p_err_q    <= p_err_d;
            f_err_q    <= f_err_d;
            armed_q    <= armed_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            ovr_q      <= ovr_d;
        end
    end

    assign bus.data_out   = data_q;
    assign bus.rx_valid   = valid_q;
    assign bus.parity_err = perr_q;
    assign bus.frame_err  = ferr_q;
    assign bus.overrun    = ovr_q;
    assign bus.rx_busy    = (state_q != StIdle);
endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Bench for uart_rx_deserializer: table of directed frames, hand-written corner sequences,
// then random frames checked against a frame-level model of the receiver and handshake.
module tb_uart_rx_deserializer;
    localparam int unsigned OVERSAMPLE = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] tick_ctr = 2'd0;
    int         n_tests = 0;
    int         n_fail = 0;
    logic       busy_seen;

    logic [7:0] m_data;
    logic       m_valid, m_perr, m_ferr, m_ovr;

    typedef struct {
        logic [7:0] d;
        logic       par;
        logic       s1;
        logic       s2;
        logic       ack;
        logic [7:0] e_data;
        logic       e_valid;
        logic       e_perr;
        logic       e_ferr;
        logic       e_ovr;
    } vec_t;

    vec_t vecs[8];

    uart_rx_deserializer_if #(.DATA_W(8)) bus ();

    uart_rx_deserializer #(
        .OVERSAMPLE(OVERSAMPLE),
        .DATA_W    (8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // One tick every four clocks.
    always @(posedge clk) tick_ctr <= tick_ctr + 2'd1;
    assign bus.tick_rx = (tick_ctr == 2'd3);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_data  = 8'h00;
        m_valid = 1'b0;
        m_perr  = 1'b0;
        m_ferr  = 1'b0;
        m_ovr   = 1'b0;
    endtask

    // Frame-level view: even parity over the data, both stop bits must be 1.
    task automatic model_frame(input logic [7:0] d, input logic par, input logic s1,
                               input logic s2, input logic ack_now);
        logic perr;
        logic ferr;
        perr = par ^ (($countones(d) % 2) == 1);
        ferr = !(s1 && s2);
        if (!m_valid || ack_now) begin
            m_data  = d;
            m_perr  = perr;
            m_ferr  = ferr;
            m_valid = 1'b1;
            if (ack_now) m_ovr = 1'b0;
        end else begin
            m_ovr = 1'b1;
        end
    endtask

    task automatic model_ack();
        if (m_valid) begin
            m_valid = 1'b0;
            m_perr  = 1'b0;
            m_ferr  = 1'b0;
            m_ovr   = 1'b0;
        end
    endtask

    task automatic check_out(input string name);
        chk({name, ".data"}, 32'(bus.data_out), 32'(m_data));
        chk({name, ".valid"}, 32'(bus.rx_valid), 32'(m_valid));
        chk({name, ".perr"}, 32'(bus.parity_err), 32'(m_perr));
        chk({name, ".ferr"}, 32'(bus.frame_err), 32'(m_ferr));
        chk({name, ".ovr"}, 32'(bus.overrun), 32'(m_ovr));
        chk({name, ".busy"}, 32'(bus.rx_busy), 32'd0);
    endtask

    // Called at #1 after an edge; returns #1 after the next tick edge.
    task automatic wait_tick(input bit ack_at);
        while (!bus.tick_rx) begin
            @(posedge clk);
            #1;
            if (bus.rx_busy) busy_seen = 1'b1;
        end
        if (ack_at) bus.rx_ack = 1'b1;
        @(posedge clk);
        #1;
        bus.rx_ack = 1'b0;
        if (bus.rx_busy) busy_seen = 1'b1;
    endtask

    task automatic pulse_ack();
        bus.rx_ack = 1'b1;
        @(posedge clk);
        #1;
        bus.rx_ack = 1'b0;
        model_ack();
        wait_tick(1'b0);
    endtask

    // Each bit lasts OVERSAMPLE ticks; the receiver samples bit b on the ninth tick of its
    // window, which is where the optional glitch and the coincident ack are placed.
    task automatic send_frame(input logic [7:0] d, input logic par, input logic s1,
                              input logic s2, input int idle, input bit ack_commit,
                              input int glitch_bit);
        logic [11:0] bits;
        bits = {s2, s1, par, d, 1'b0};
        for (int b = 0; b < 12; b++) begin
            bus.rx = bits[b];
            for (int j = 1; j <= int'(OVERSAMPLE); j++) begin
                if (b == glitch_bit && j == 9)  bus.rx = ~bits[b];
                if (b == glitch_bit && j == 10) bus.rx = bits[b];
                wait_tick(ack_commit && b == 11 && j == 9);
            end
        end
        bus.rx = 1'b1;
        for (int j = 0; j < idle; j++) wait_tick(1'b0);
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;
        logic       par, s1, s2, ack, coin;
        int         idle;

        vecs[0] = '{8'hA5, 1'b0, 1'b1, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{8'h01, 1'b0, 1'b1, 1'b1, 1'b1, 8'h01, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{8'h3C, 1'b0, 1'b0, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{8'h11, 1'b0, 1'b1, 1'b1, 1'b1, 8'h3C, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[4] = '{8'h11, 1'b0, 1'b1, 1'b1, 1'b0, 8'h11, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{8'h22, 1'b0, 1'b1, 1'b1, 1'b1, 8'h11, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[6] = '{8'h80, 1'b1, 1'b1, 1'b1, 1'b1, 8'h80, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{8'h7F, 1'b1, 1'b1, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b0, 1'b1, 1'b0};

        rst        = 1'b1;
        bus.rx     = 1'b1;
        bus.rx_ack = 1'b0;
        busy_seen  = 1'b0;
        model_reset();
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b0;
        check_out("reset");
        for (int i = 0; i < 4; i++) wait_tick(1'b0);

        for (int i = 0; i < 8; i++) begin
            send_frame(vecs[i].d, vecs[i].par, vecs[i].s1, vecs[i].s2, 4, 1'b0, -1);
            model_frame(vecs[i].d, vecs[i].par, vecs[i].s1, vecs[i].s2, 1'b0);
            chk($sformatf("vec%0d.data", i), 32'(bus.data_out), 32'(vecs[i].e_data));
            chk($sformatf("vec%0d.valid", i), 32'(bus.rx_valid), 32'(vecs[i].e_valid));
            chk($sformatf("vec%0d.perr", i), 32'(bus.parity_err), 32'(vecs[i].e_perr));
            chk($sformatf("vec%0d.ferr", i), 32'(bus.frame_err), 32'(vecs[i].e_ferr));
            chk($sformatf("vec%0d.ovr", i), 32'(bus.overrun), 32'(vecs[i].e_ovr));
            if (vecs[i].ack) begin
                pulse_ack();
                chk($sformatf("vec%0d.ack_valid", i), 32'(bus.rx_valid), 32'd0);
                chk($sformatf("vec%0d.ack_flags", i),
                    32'({bus.parity_err, bus.frame_err, bus.overrun}), 32'd0);
                chk($sformatf("vec%0d.ack_data", i), 32'(bus.data_out), 32'(vecs[i].e_data));
            end
        end

        // Short low pulse: start rejected at mid-bit, nothing delivered.
        busy_seen = 1'b0;
        bus.rx    = 1'b0;
        for (int i = 0; i < 4; i++) wait_tick(1'b0);
        bus.rx = 1'b1;
        for (int i = 0; i < 12; i++) wait_tick(1'b0);
        chk("glitch.busy_pulse", 32'(busy_seen), 32'd1);
        check_out("glitch");

        // Coincident ack at the commit edge replaces the held byte and clears overrun.
        send_frame(8'h11, 1'b0, 1'b1, 1'b1, 4, 1'b0, -1);
        model_frame(8'h11, 1'b0, 1'b1, 1'b1, 1'b0);
        send_frame(8'h22, 1'b0, 1'b1, 1'b1, 4, 1'b1, -1);
        model_frame(8'h22, 1'b0, 1'b1, 1'b1, 1'b1);
        chk("coin1.data", 32'(bus.data_out), 32'h22);
        check_out("coin1");
        send_frame(8'h33, 1'b0, 1'b1, 1'b1, 4, 1'b0, -1);
        model_frame(8'h33, 1'b0, 1'b1, 1'b1, 1'b0);
        check_out("coin2_ovr");
        send_frame(8'h44, 1'b0, 1'b1, 1'b1, 4, 1'b1, -1);
        model_frame(8'h44, 1'b0, 1'b1, 1'b1, 1'b1);
        check_out("coin3");
        pulse_ack();

        // Break: line held low delivers 0x00 with frame_err, then no re-arm while low.
        bus.rx = 1'b0;
        for (int i = 0; i < 220; i++) wait_tick(1'b0);
        model_frame(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        check_out("break");
        pulse_ack();
        check_out("break_ack");
        for (int i = 0; i < 40; i++) wait_tick(1'b0);
        chk("break.no_rearm", 32'(bus.rx_busy), 32'd0);
        chk("break.no_valid", 32'(bus.rx_valid), 32'd0);
        bus.rx = 1'b1;
        for (int i = 0; i < 4; i++) wait_tick(1'b0);
        send_frame(8'h3C, 1'b0, 1'b1, 1'b1, 4, 1'b0, -1);
        model_frame(8'h3C, 1'b0, 1'b1, 1'b1, 1'b0);
        check_out("after_break");

        // Reset in the middle of data bit 4 with an unread byte pending.
        bus.rx = 1'b0;
        for (int i = 0; i < 16; i++) wait_tick(1'b0);
        for (int b = 0; b < 4; b++) begin
            bus.rx = b[0];
            for (int i = 0; i < 16; i++) wait_tick(1'b0);
        end
        bus.rx = 1'b1;
        for (int i = 0; i < 8; i++) wait_tick(1'b0);
        chk("rst.busy_before", 32'(bus.rx_busy), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        chk("rst.busy", 32'(bus.rx_busy), 32'd0);
        chk("rst.valid", 32'(bus.rx_valid), 32'd0);
        for (int i = 0; i < 4; i++) wait_tick(1'b0);
        check_out("rst_idle");
        send_frame(8'h5A, 1'b0, 1'b1, 1'b1, 4, 1'b0, -1);
        model_frame(8'h5A, 1'b0, 1'b1, 1'b1, 1'b0);
        check_out("after_rst");
        pulse_ack();

        // One-tick glitch exactly at the data bit 2 sample point.
        send_frame(8'h5A, 1'b0, 1'b1, 1'b1, 4, 1'b0, 3);
`ifdef UART_RX_MAJORITY_EN
        model_frame(8'h5A, 1'b0, 1'b1, 1'b1, 1'b0);
`else
        model_frame(8'h5A ^ 8'h04, 1'b0, 1'b1, 1'b1, 1'b0);
`endif
        check_out("sample_glitch");
        pulse_ack();

        for (int i = 0; i < 25; i++) begin
            d    = 8'($urandom_range(0, 255));
            par  = (($countones(d) % 2) == 1) ^ ($urandom_range(0, 3) == 0);
            s1   = ($urandom_range(0, 7) != 0);
            s2   = ($urandom_range(0, 7) != 0);
            ack  = ($urandom_range(0, 1) == 1);
            coin = ($urandom_range(0, 4) == 0);
            idle = int'($urandom_range(2, 6));
            send_frame(d, par, s1, s2, idle, coin, -1);
            model_frame(d, par, s1, s2, coin);
            check_out($sformatf("rand%0d", i));
            if (ack) begin
                pulse_ack();
                check_out($sformatf("rand%0d_ack", i));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
